// File: rtl/tv80_bus_arbiter.sv
// Arbitrates the shared test memory between the tv80s CPU and a DMA/loader requester.
// The CPU is parked through busrq_n/busak_n while bounded DMA bursts run.
module tv80_bus_arbiter #(
    parameter int BURST_MAX   = 16,
    parameter int REQ_TIMEOUT = 255,
    parameter int HOLDOFF     = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [15:0] cpu_a,
    input  logic [7:0]  cpu_do,
    input  logic        cpu_mreq_n,
    input  logic        cpu_iorq_n,
    input  logic        cpu_wr_n,
    output logic        cpu_busrq_n,
    input  logic        cpu_busak_n,
    input  logic        dma_req,
    input  logic        dma_we,
    input  logic [15:0] dma_addr,
    input  logic [7:0]  dma_wdata,
    output logic        dma_gnt,
    output logic        dma_ack,
    output logic [7:0]  dma_rdata,
    output logic [15:0] mem_a,
    output logic        mem_we,
    output logic [7:0]  mem_wdata,
    input  logic [7:0]  mem_rdata,
    output logic        timeout_err,
    input  logic        err_clr
);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_REQ  = 3'd1,
        ST_ADDR = 3'd2,
        ST_ACK  = 3'd3,
        ST_REL  = 3'd4,
        ST_HOLD = 3'd5
    } state_t;

    localparam logic [7:0] BURST_LIM = 8'(BURST_MAX);
    localparam logic [7:0] TMO_LAST  = 8'(REQ_TIMEOUT - 1);
    localparam logic [7:0] HOLD_LAST = 8'(HOLDOFF - 1);

    state_t      state_r;
    state_t      state_nxt_s;
    logic        tmo_hit_s;
    logic [7:0]  burst_cnt_r;
    logic [7:0]  tmo_cnt_r;
    logic [7:0]  hold_cnt_r;
    logic [15:0] addr_r;
    logic [7:0]  wdata_r;
    logic        we_r;
    logic        busrq_n_r;
    logic        gnt_r;
    logic        ack_r;
    logic        err_r;

    // Next-state decode; busak_n only matters in REQ and REL.
    always_comb begin
        state_nxt_s = state_r;
        tmo_hit_s   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (dma_req) state_nxt_s = ST_REQ;
                else         state_nxt_s = ST_IDLE;
            end
            ST_REQ: begin
                if (!cpu_busak_n) begin
                    state_nxt_s = ST_ADDR;
                end else if (tmo_cnt_r == TMO_LAST) begin
                    tmo_hit_s   = 1'b1;
                    state_nxt_s = ST_HOLD;
                end else begin
                    state_nxt_s = ST_REQ;
                end
            end
            ST_ADDR: begin
                if (dma_req) state_nxt_s = ST_ACK;
                else         state_nxt_s = ST_REL;
            end
            ST_ACK: begin
                if (burst_cnt_r + 8'd1 == BURST_LIM) state_nxt_s = ST_REL;
                else                                  state_nxt_s = ST_ADDR;
            end
            ST_REL: begin
                if (cpu_busak_n) state_nxt_s = ST_HOLD;
                else             state_nxt_s = ST_REL;
            end
            ST_HOLD: begin
                if (hold_cnt_r == HOLD_LAST) state_nxt_s = ST_IDLE;
                else                         state_nxt_s = ST_HOLD;
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // State register and registered handshake outputs, decoded from the next state.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r   <= ST_IDLE;
            busrq_n_r <= 1'b1;
            gnt_r     <= 1'b0;
            ack_r     <= 1'b0;
        end else begin
            state_r   <= state_nxt_s;
            busrq_n_r <= !(state_nxt_s == ST_REQ || state_nxt_s == ST_ADDR || state_nxt_s == ST_ACK);
            gnt_r     <= (state_nxt_s == ST_ADDR || state_nxt_s == ST_ACK);
            ack_r     <= (state_nxt_s == ST_ACK);
        end
    end

    // Burst, timeout and holdoff counters; each restarts on entry to its state.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            burst_cnt_r <= 8'd0;
            tmo_cnt_r   <= 8'd0;
            hold_cnt_r  <= 8'd0;
        end else begin
            if (state_nxt_s == ST_REQ && state_r != ST_REQ) begin
                burst_cnt_r <= 8'd0;
                tmo_cnt_r   <= 8'd0;
            end else begin
                if (state_r == ST_ACK) burst_cnt_r <= burst_cnt_r + 8'd1;
                else                   burst_cnt_r <= burst_cnt_r;
                if (state_r == ST_REQ) tmo_cnt_r <= tmo_cnt_r + 8'd1;
                else                   tmo_cnt_r <= tmo_cnt_r;
            end
            if (state_nxt_s == ST_HOLD && state_r != ST_HOLD) hold_cnt_r <= 8'd0;
            else if (state_r == ST_HOLD)                      hold_cnt_r <= hold_cnt_r + 8'd1;
            else                                              hold_cnt_r <= hold_cnt_r;
        end
    end

    // Access capture in ADDR; the sticky error favours set over clear.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            addr_r  <= 16'h0000;
            wdata_r <= 8'h00;
            we_r    <= 1'b0;
            err_r   <= 1'b0;
        end else begin
            if (state_r == ST_ADDR && dma_req) begin
                addr_r  <= dma_addr;
                wdata_r <= dma_wdata;
                we_r    <= dma_we;
            end else begin
                addr_r  <= addr_r;
                wdata_r <= wdata_r;
                we_r    <= we_r;
            end
            if (tmo_hit_s)    err_r <= 1'b1;
            else if (err_clr) err_r <= 1'b0;
            else              err_r <= err_r;
        end
    end

    // Memory mux: DMA drives the address during ADDR so the synchronous read lands in ACK.
    always_comb begin
        mem_a     = cpu_a;
        mem_wdata = cpu_do;
        mem_we    = 1'b0;
        case (state_r)
            ST_ADDR: begin
                mem_a     = dma_addr;
                mem_wdata = dma_wdata;
                mem_we    = 1'b0;
            end
            ST_ACK: begin
                mem_a     = addr_r;
                mem_wdata = wdata_r;
                mem_we    = we_r;
            end
            default: begin
                if (!cpu_iorq_n) mem_a = {8'h10, cpu_a[7:0]};
                else             mem_a = cpu_a;
                mem_wdata = cpu_do;
                mem_we    = ~cpu_wr_n & (~cpu_mreq_n | ~cpu_iorq_n);
            end
        endcase
    end

    assign cpu_busrq_n = busrq_n_r;
    assign dma_gnt     = gnt_r;
    assign dma_ack     = ack_r;
    assign dma_rdata   = mem_rdata;
    assign timeout_err = err_r;

endmodule

// File: tb/tb_tv80_bus_arbiter.sv
// Directed bench for tv80_bus_arbiter: synchronous test memory, auto-acknowledging CPU,
// one task per scenario with hand-computed expectations.
module tb_tv80_bus_arbiter;

    localparam int BURST_MAX   = 4;
    localparam int REQ_TIMEOUT = 8;
    localparam int HOLDOFF     = 4;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [15:0] cpu_a;
    logic [7:0]  cpu_do;
    logic        cpu_mreq_n, cpu_iorq_n, cpu_wr_n;
    logic        cpu_busrq_n;
    logic        cpu_busak_n = 1'b1;
    logic        dma_req, dma_we;
    logic [15:0] dma_addr;
    logic [7:0]  dma_wdata;
    logic        dma_gnt, dma_ack;
    logic [7:0]  dma_rdata;
    logic [15:0] mem_a;
    logic        mem_we;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata = 8'h00;
    logic        timeout_err;
    logic        err_clr;
    logic        ack_en = 1'b1;

    logic [7:0]  mem [0:65535];
    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    tv80_bus_arbiter #(
        .BURST_MAX(BURST_MAX), .REQ_TIMEOUT(REQ_TIMEOUT), .HOLDOFF(HOLDOFF)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .cpu_a(cpu_a), .cpu_do(cpu_do),
        .cpu_mreq_n(cpu_mreq_n), .cpu_iorq_n(cpu_iorq_n), .cpu_wr_n(cpu_wr_n),
        .cpu_busrq_n(cpu_busrq_n), .cpu_busak_n(cpu_busak_n),
        .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
        .dma_gnt(dma_gnt), .dma_ack(dma_ack), .dma_rdata(dma_rdata),
        .mem_a(mem_a), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .timeout_err(timeout_err), .err_clr(err_clr)
    );

    // Synchronous test memory: write and registered read on the rising edge.
    always @(posedge clk) begin
        if (mem_we) mem[mem_a] <= mem_wdata;
        mem_rdata <= mem[mem_a];
    end

    // CPU model: acknowledges a bus request half a cycle after seeing it.
    always @(negedge clk) begin
        cpu_busak_n = ack_en ? cpu_busrq_n : 1'b1;
    end

    task automatic test_reset;
        reset_n = 1'b0;
        cpu_a = 16'h1234; cpu_do = 8'h00;
        cpu_mreq_n = 1'b1; cpu_iorq_n = 1'b1; cpu_wr_n = 1'b1;
        dma_req = 1'b0; dma_we = 1'b0; dma_addr = 16'h0000; dma_wdata = 8'h00;
        err_clr = 1'b0;
        repeat (3) @(negedge clk);
        total++; if (cpu_busrq_n !== 1'b1) begin bad++; $display("FAIL rst_busrq got=%b exp=1", cpu_busrq_n); end
        total++; if (dma_gnt !== 1'b0) begin bad++; $display("FAIL rst_gnt got=%b exp=0", dma_gnt); end
        total++; if (dma_ack !== 1'b0) begin bad++; $display("FAIL rst_ack got=%b exp=0", dma_ack); end
        total++; if (timeout_err !== 1'b0) begin bad++; $display("FAIL rst_err got=%b exp=0", timeout_err); end
        total++; if (mem_we !== 1'b0) begin bad++; $display("FAIL rst_mem_we got=%b exp=0", mem_we); end
        total++; if (mem_a !== 16'h1234) begin bad++; $display("FAIL rst_mem_a got=%h exp=1234", mem_a); end
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_single_write;
        bit hi_ok = 1'b1;
        dma_we = 1'b1; dma_addr = 16'h4000; dma_wdata = 8'hA5; dma_req = 1'b1;
        @(negedge clk);
        total++; if (cpu_busrq_n !== 1'b0) begin bad++; $display("FAIL wr_busrq_fall got=%b exp=0", cpu_busrq_n); end
        total++; if (dma_gnt !== 1'b0) begin bad++; $display("FAIL wr_gnt_early got=%b exp=0", dma_gnt); end
        @(negedge clk);
        total++; if (dma_gnt !== 1'b1) begin bad++; $display("FAIL wr_gnt got=%b exp=1", dma_gnt); end
        total++; if (dma_ack !== 1'b0) begin bad++; $display("FAIL wr_ack_early got=%b exp=0", dma_ack); end
        @(negedge clk);
        total++; if (dma_ack !== 1'b1) begin bad++; $display("FAIL wr_ack got=%b exp=1", dma_ack); end
        total++; if (mem_a !== 16'h4000 || mem_we !== 1'b1 || mem_wdata !== 8'hA5) begin
            bad++; $display("FAIL wr_bus got=%h/%b/%h exp=4000/1/a5", mem_a, mem_we, mem_wdata);
        end
        dma_req = 1'b0;
        @(negedge clk);
        total++; if (mem[16'h4000] !== 8'hA5) begin bad++; $display("FAIL wr_mem got=%h exp=a5", mem[16'h4000]); end
        total++; if (dma_ack !== 1'b0) begin bad++; $display("FAIL wr_single_ack got=%b exp=0", dma_ack); end
        @(negedge clk);
        total++; if (cpu_busrq_n !== 1'b1 || dma_gnt !== 1'b0) begin
            bad++; $display("FAIL wr_release got busrq=%b gnt=%b exp 1/0", cpu_busrq_n, dma_gnt);
        end
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (cpu_busrq_n !== 1'b1) hi_ok = 1'b0;
        end
        total++; if (!hi_ok) begin bad++; $display("FAIL wr_cpu_resume got=low exp=high"); end
    endtask

    task automatic test_burst_limit;
        int acks = 0;
        int last_ack = -10;
        int rel_at = -1;
        int hi = 1;
        int acks2 = 0;
        bit seen_low = 1'b0;
        bit gnt2 = 1'b0;
        bit rel2 = 1'b0;
        dma_we = 1'b1; dma_addr = 16'h5000; dma_wdata = 8'h30; dma_req = 1'b1;
        for (int i = 0; i < 40 && rel_at < 0; i++) begin
            @(negedge clk);
            if (cpu_busrq_n === 1'b0) seen_low = 1'b1;
            if (dma_ack === 1'b1) begin
                acks++; last_ack = i;
                dma_addr = dma_addr + 16'd1; dma_wdata = dma_wdata + 8'd1;
            end
            if (seen_low && cpu_busrq_n === 1'b1) rel_at = i;
        end
        total++; if (acks != BURST_MAX) begin bad++; $display("FAIL burst_acks got=%0d exp=%0d", acks, BURST_MAX); end
        total++; if (rel_at != last_ack + 1) begin bad++; $display("FAIL burst_rel_cycle got=%0d exp=%0d", rel_at, last_ack + 1); end
        for (int i = 0; i < 20 && cpu_busrq_n === 1'b1; i++) begin
            @(negedge clk);
            if (cpu_busrq_n === 1'b1) hi++;
        end
        total++; if (hi != HOLDOFF + 2) begin bad++; $display("FAIL burst_holdoff got=%0d exp=%0d", hi, HOLDOFF + 2); end
        dma_req = 1'b0;
        for (int i = 0; i < 10 && !rel2; i++) begin
            @(negedge clk);
            if (dma_gnt === 1'b1) gnt2 = 1'b1;
            if (dma_ack === 1'b1) acks2++;
            if (cpu_busrq_n === 1'b1) rel2 = 1'b1;
        end
        total++; if (!gnt2 || acks2 != 0 || !rel2) begin
            bad++; $display("FAIL burst_drop_in_req got gnt=%b acks=%0d rel=%b exp 1/0/1", gnt2, acks2, rel2);
        end
        for (int k = 0; k < 5; k++) begin
            total++; if (mem[16'h5000 + k] !== 8'h30 + 8'(k) && k < 4 || k == 4 && mem[16'h5004] !== 8'h00) begin
                bad++; $display("FAIL burst_mem[%0d] got=%h", k, mem[16'h5000 + k]);
            end
        end
        repeat (8) @(negedge clk);
    endtask

    task automatic test_read;
        bit seen = 1'b0;
        mem[16'hF2DA] = 8'h03;
        dma_we = 1'b0; dma_addr = 16'hF2DA; dma_wdata = 8'hFF; dma_req = 1'b1;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (dma_ack === 1'b1) begin
                seen = 1'b1;
                total++; if (dma_rdata !== 8'h03) begin bad++; $display("FAIL rd_data got=%h exp=03", dma_rdata); end
                total++; if (mem_we !== 1'b0) begin bad++; $display("FAIL rd_we got=%b exp=0", mem_we); end
            end
        end
        total++; if (!seen) begin bad++; $display("FAIL rd_ack_timeout got=none exp=ack"); end
        dma_req = 1'b0;
        repeat (10) @(negedge clk);
        total++; if (mem[16'hF2DA] !== 8'h03) begin bad++; $display("FAIL rd_mem_kept got=%h exp=03", mem[16'hF2DA]); end
    endtask

    task automatic test_cpu_io;
        bit hi_ok = 1'b1;
        cpu_a = 16'h7055; cpu_do = 8'h70; cpu_iorq_n = 1'b0; cpu_wr_n = 1'b0;
        #1;
        total++; if (mem_a !== 16'h1055 || mem_we !== 1'b1 || mem_wdata !== 8'h70) begin
            bad++; $display("FAIL io_bus got=%h/%b/%h exp=1055/1/70", mem_a, mem_we, mem_wdata);
        end
        @(negedge clk);
        if (cpu_busrq_n !== 1'b1) hi_ok = 1'b0;
        cpu_iorq_n = 1'b1; cpu_wr_n = 1'b1;
        total++; if (mem[16'h1055] !== 8'h70) begin bad++; $display("FAIL io_mem got=%h exp=70", mem[16'h1055]); end
        cpu_a = 16'h2345; cpu_do = 8'h5A; cpu_mreq_n = 1'b0;
        #1;
        total++; if (mem_a !== 16'h2345 || mem_we !== 1'b0) begin
            bad++; $display("FAIL cpu_rd_bus got=%h/%b exp=2345/0", mem_a, mem_we);
        end
        cpu_wr_n = 1'b0;
        #1;
        total++; if (mem_we !== 1'b1) begin bad++; $display("FAIL cpu_wr_we got=%b exp=1", mem_we); end
        @(negedge clk);
        if (cpu_busrq_n !== 1'b1) hi_ok = 1'b0;
        cpu_mreq_n = 1'b1; cpu_wr_n = 1'b1;
        total++; if (mem[16'h2345] !== 8'h5A) begin bad++; $display("FAIL cpu_wr_mem got=%h exp=5a", mem[16'h2345]); end
        total++; if (!hi_ok) begin bad++; $display("FAIL io_busrq got=low exp=high"); end
    endtask

    task automatic test_timeout;
        int lows = 0;
        bit fell = 1'b0;
        bit done = 1'b0;
        ack_en = 1'b0;
        dma_we = 1'b0; dma_req = 1'b1;
        for (int i = 0; i < 30 && timeout_err !== 1'b1; i++) begin
            @(negedge clk);
            if (cpu_busrq_n === 1'b0) lows++;
        end
        total++; if (lows != REQ_TIMEOUT) begin bad++; $display("FAIL tmo_req_cycles got=%0d exp=%0d", lows, REQ_TIMEOUT); end
        total++; if (timeout_err !== 1'b1 || cpu_busrq_n !== 1'b1) begin
            bad++; $display("FAIL tmo_abort got err=%b busrq=%b exp 1/1", timeout_err, cpu_busrq_n);
        end
        dma_req = 1'b0;
        @(negedge clk);
        total++; if (timeout_err !== 1'b1) begin bad++; $display("FAIL tmo_sticky got=%b exp=1", timeout_err); end
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        total++; if (timeout_err !== 1'b0) begin bad++; $display("FAIL tmo_clear got=%b exp=0", timeout_err); end
        repeat (4) @(negedge clk);
        err_clr = 1'b1; dma_req = 1'b1;
        for (int i = 0; i < 30 && !done; i++) begin
            @(negedge clk);
            if (cpu_busrq_n === 1'b0) fell = 1'b1;
            if (fell && cpu_busrq_n === 1'b1) begin
                done = 1'b1;
                total++; if (timeout_err !== 1'b1) begin bad++; $display("FAIL tmo_set_wins got=%b exp=1", timeout_err); end
            end
        end
        total++; if (!done) begin bad++; $display("FAIL tmo_second_abort got=none exp=abort"); end
        dma_req = 1'b0;
        @(negedge clk);
        total++; if (timeout_err !== 1'b0) begin bad++; $display("FAIL tmo_clr_after got=%b exp=0", timeout_err); end
        err_clr = 1'b0; ack_en = 1'b1;
        repeat (8) @(negedge clk);
    endtask

    task automatic test_reset_mid_burst;
        bit seen = 1'b0;
        mem[16'h6000] = 8'h11;
        dma_we = 1'b1; dma_addr = 16'h6000; dma_wdata = 8'hEE; dma_req = 1'b1;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (dma_ack === 1'b1) seen = 1'b1;
        end
        total++; if (!seen) begin bad++; $display("FAIL rmb_ack_timeout got=none exp=ack"); end
        reset_n = 1'b0;
        #1;
        total++; if (cpu_busrq_n !== 1'b1 || dma_gnt !== 1'b0 || dma_ack !== 1'b0 || mem_we !== 1'b0) begin
            bad++; $display("FAIL rmb_async got busrq=%b gnt=%b ack=%b we=%b exp 1/0/0/0",
                            cpu_busrq_n, dma_gnt, dma_ack, mem_we);
        end
        @(negedge clk);
        total++; if (mem[16'h6000] !== 8'h11) begin bad++; $display("FAIL rmb_mem got=%h exp=11", mem[16'h6000]); end
        dma_req = 1'b0;
        reset_n = 1'b1;
        repeat (3) @(negedge clk);
        total++; if (cpu_busrq_n !== 1'b1 || dma_ack !== 1'b0) begin
            bad++; $display("FAIL rmb_idle got busrq=%b ack=%b exp 1/0", cpu_busrq_n, dma_ack);
        end
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
        test_reset();
        test_single_write();
        test_burst_limit();
        test_read();
        test_cpu_io();
        test_timeout();
        test_reset_mid_burst();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/tv80_bus_arbiter.md
# tv80_bus_arbiter

Shares the single 64 KiB test memory between the tv80s CPU and a DMA/loader requester. Uses the CPU's busrq_n/busak_n handshake to take the bus, runs bounded bursts for the requester, then hands the bus back. When the CPU owns the bus, the block also performs the bench's IO decode onto the shared memory.

## Interface
- BURST_MAX, 16: maximum DMA accesses per bus tenure (1..255).
- REQ_TIMEOUT, 255: cycles to wait for busak_n low before aborting (1..255).
- HOLDOFF, 4: minimum cycles the CPU keeps the bus between tenures (1..15).
- clk  in  1  single clock; all state on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- cpu_a  in  16  CPU address.
- cpu_do  in  8  CPU write data.
- cpu_mreq_n, cpu_iorq_n, cpu_wr_n  in  1 each  CPU strobes.
- cpu_busrq_n  out  1  bus request to CPU.
- cpu_busak_n  in  1  bus acknowledge from CPU.
- dma_req  in  1  level; requester wants accesses.
- dma_we  in  1  1 = write, 0 = read; sampled with dma_addr.
- dma_addr  in  16  DMA address.
- dma_wdata  in  8  DMA write data.
- dma_gnt  out  1  high while the requester owns the bus.
- dma_ack  out  1  one-cycle pulse per completed access.
- dma_rdata  out  8  read data, valid while dma_ack is high.
- mem_a  out  16  shared memory address.
- mem_we  out  1  shared memory write enable.
- mem_wdata  out  8  shared memory write data.
- mem_rdata  in  8  memory read data, one cycle after mem_a.
- timeout_err  out  1  sticky; set on request timeout.
- err_clr  in  1  synchronous clear of timeout_err.

## Operation
- States:
  - IDLE: CPU owns the bus. Goes to REQ when dma_req=1.
  - REQ: cpu_busrq_n=0. Goes to ADDR when cpu_busak_n=0. Goes to HOLD on timeout.
  - ADDR: dma_gnt=1. If dma_req=1, present the access and go to ACK. If dma_req=0, go to REL.
  - ACK: dma_ack=1 and burst count++. Goes to REL if count==BURST_MAX, else back to ADDR.
  - REL: cpu_busrq_n=1 and dma_gnt=0. Goes to HOLD when cpu_busak_n=1.
  - HOLD: count HOLDOFF cycles, then go to IDLE.
- Mux when the CPU owns the bus (every state except ADDR/ACK):
  - mem_a = cpu_iorq_n==0 ? {8'h10, cpu_a[7:0]} : cpu_a.
  - mem_we = ~cpu_wr_n & (~cpu_mreq_n | ~cpu_iorq_n).
  - mem_wdata = cpu_do.
  - The mux is combinational.
- Mux in ADDR/ACK:
  - mem_a = dma_addr registered in ADDR.
  - mem_wdata = dma_wdata registered in ADDR.
  - mem_we = registered dma_we, asserted during ACK only.
  - dma_rdata = mem_rdata.
- The requester must hold dma_addr, dma_we and dma_wdata stable from ADDR until dma_ack.
- The burst counter is 8 bits and is cleared on entry to REQ.
- The timeout counter is 8 bits, cleared on entry to REQ, and increments each REQ cycle. Reaching REQ_TIMEOUT sets timeout_err and moves to HOLD with cpu_busrq_n=1.
- If err_clr and a timeout occur in the same cycle, set wins.
- dma_req dropping in REQ does not abort. The arbiter completes the handshake, then releases from ADDR.

## Timing
- Reset values:
  - cpu_busrq_n=1, dma_gnt=0, dma_ack=0, timeout_err=0, state IDLE, all counters 0.
  - mem_* follow the CPU mux, with mem_we=0 while the CPU strobes are idle.
  - dma_rdata = mem_rdata.
- Asserting reset_n low mid-burst forces IDLE immediately. Any in-flight DMA write is dropped and no dma_ack is issued.
- Request latency: cpu_busrq_n falls 1 cycle after dma_req rises in IDLE.
- Grant latency: dma_gnt rises 1 cycle after cpu_busak_n=0 is sampled.
- Each access takes 2 cycles (ADDR, ACK), so peak rate is 1 access per 2 cycles.
- Release: cpu_busrq_n rises the cycle after the final ACK.
- Re-request: no new request is made earlier than HOLDOFF cycles after busak_n is seen high.
- cpu_busak_n is sampled only in REQ and REL. A glitch in other states is ignored.

## Test plan
- Single write: dma_req with dma_we=1, addr=16'h4000, data=8'hA5, then dma_req drops.
  - busrq_n falls and busak_n follows.
  - One dma_ack, after which mem[16'h4000]=8'hA5.
  - busrq_n returns high and the CPU resumes.
- Burst limit: BURST_MAX=4 with dma_req held high.
  - Exactly 4 acks, then REL.
  - HOLDOFF idle cycles, then a new tenure.
- Read: mem[16'hF2DA]=8'h03 and a DMA read of 16'hF2DA.
  - dma_rdata=8'h03 during dma_ack.
- CPU IO: the CPU executes OUT (8'h55),A with A=8'h70 while no DMA is active.
  - mem[16'h1055]=8'h70.
  - cpu_busrq_n stays high throughout.
- Timeout: busak_n forced high and REQ_TIMEOUT=8.
  - timeout_err rises after 8 REQ cycles and busrq_n=1.
  - err_clr pulse clears timeout_err.
- Reset mid-burst: drop reset_n during ACK of a write.
  - Outputs take their reset values asynchronously.
  - The target memory location is unchanged.
